// File: rtl/seq_calc_pkg.sv
// seq_calc_pkg: shared encodings for the sequential calculator.
//   - opcode encodings carried on the op field
//   - control FSM state enum
//   - bit positions inside the one-hot op_flag output
//   - mode select for the shared shift/iterate datapath
package seq_calc_pkg;

  localparam int OP_W  = 3;
  localparam int OPF_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;

  localparam int OPF_ADD = 0;
  localparam int OPF_SUB = 1;
  localparam int OPF_MUL = 2;
  localparam int OPF_DIV = 3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_calc_if.sv
// seq_calc_if: start/busy/done request bus of the sequential calculator.
//   master: start, op, a, b             (requester drives)
//   slave : busy, done, result, remainder, op_flag, div_by_zero, illegal_op
interface seq_calc_if
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int RES_W = 2 * WIDTH;

  logic                start;
  logic [OP_W-1:0]     op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                busy;
  logic                done;
  logic [RES_W-1:0]    result;
  logic [WIDTH-1:0]    remainder;
  logic [OPF_W-1:0]    op_flag;
  logic                div_by_zero;
  logic                illegal_op;

  modport master (
    output start, op, a, b,
    input  busy, done, result, remainder, op_flag, div_by_zero, illegal_op
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, remainder, op_flag, div_by_zero, illegal_op
  );

endinterface

// File: rtl/seq_calc_iter_unit.sv
// seq_calc_iter_unit: shared one-bit-per-cycle shift datapath.
//   MODE_MUL: shift-add multiply of two unsigned WIDTH-bit operands.
//   MODE_DIV: restoring divide of two unsigned WIDTH-bit operands.
// Ports:
//   clk          clock
//   i_load       capture i_a/i_b and clear the partial accumulator
//   i_step       perform one iteration
//   i_mode       MODE_MUL / MODE_DIV
//   i_a, i_b     multiplicand/multiplier or dividend/divisor
//   o_prod_nxt   product after the current iteration (valid on the last step)
//   o_quo_nxt    quotient after the current iteration
//   o_rem_nxt    remainder after the current iteration
// The *_nxt outputs expose the value the current step is about to commit so
// the caller can register the final answer on the same edge as the last step.
module seq_calc_iter_unit
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic                 clk,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_mode,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_prod_nxt,
  output logic [WIDTH-1:0]     o_quo_nxt,
  output logic [WIDTH-1:0]     o_rem_nxt
);

  // r_hi: partial product high half / partial remainder (one guard bit)
  // r_lo: multiplier being consumed / dividend shifting out, quotient in
  logic [WIDTH:0]     r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH+1:0]   w_diff;
  logic [WIDTH:0]     w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  always_comb begin
    w_sum     = {1'b0, r_hi[WIDTH-1:0]} + {1'b0, (r_lo[0] ? r_b : '0)};
    w_shifted = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_diff    = {1'b0, w_shifted} - {2'b00, r_b};
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    if (i_mode == MODE_MUL) begin
      // Add then shift the whole {hi,lo} pair right by one.
      w_hi_nxt = {1'b0, w_sum[WIDTH:1]};
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (w_diff[WIDTH+1]) begin
      // Trial subtraction borrowed: restore, quotient bit 0.
      w_hi_nxt = w_shifted;
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
    end else begin
      w_hi_nxt = w_diff[WIDTH:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign o_prod_nxt = {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
  assign o_quo_nxt  = w_lo_nxt;
  assign o_rem_nxt  = w_hi_nxt[WIDTH-1:0];

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle add/sub/mul/div unit on a start/busy/done bus.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    seq_calc_if.slave: start, op, a, b in; busy, done, result,
//          remainder, op_flag, div_by_zero, illegal_op out
// Build option: define SEQ_CALC_SIGNED_EN to treat a and b as two's
// complement (MUL/DIV on magnitudes with sign correction, quotient toward
// zero, remainder carries the dividend's sign). Default build is unsigned.
module seq_calculator
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic        clk,
  input  logic        rst_n,
  seq_calc_if.slave   bus
);

  localparam int RES_W = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  function automatic logic [RES_W-1:0] ext_operand(input logic [WIDTH-1:0] v);
`ifdef SEQ_CALC_SIGNED_EN
    return {{WIDTH{v[WIDTH-1]}}, v};
`else
    return {{WIDTH{1'b0}}, v};
`endif
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef SEQ_CALC_SIGNED_EN
    return v[WIDTH-1] ? (~v + 1'b1) : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [RES_W-1:0] apply_sign_res(input logic [RES_W-1:0] v,
                                                      input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign_rem(input logic [WIDTH-1:0] v,
                                                      input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_is_div;
  logic                r_neg_q;
  logic                r_neg_r;

  logic [RES_W-1:0]    r_result;
  logic [WIDTH-1:0]    r_remainder;
  logic [OPF_W-1:0]    r_op_flag;
  logic                r_div_by_zero;
  logic                r_illegal_op;

  logic                w_accept;
  logic                w_fin_fast;
  logic                w_fin_iter;
  logic [RES_W-1:0]    w_a_ext, w_b_ext;
  logic                w_neg_q, w_neg_r;

  logic                w_f_fast;
  logic                w_f_div;
  logic [RES_W-1:0]    w_f_result;
  logic [WIDTH-1:0]    w_f_rem;
  logic [OPF_W-1:0]    w_f_flag;
  logic                w_f_dbz;
  logic                w_f_ill;

  logic [RES_W-1:0]    w_prod_nxt;
  logic [WIDTH-1:0]    w_quo_nxt;
  logic [WIDTH-1:0]    w_rem_nxt;

  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_fin_fast = w_accept && w_f_fast;
  assign w_fin_iter = (r_state == RUN) && (r_cnt == '0);

  assign w_a_ext = ext_operand(bus.a);
  assign w_b_ext = ext_operand(bus.b);
`ifdef SEQ_CALC_SIGNED_EN
  assign w_neg_q = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
  assign w_neg_r = bus.a[WIDTH-1];
`else
  assign w_neg_q = 1'b0;
  assign w_neg_r = 1'b0;
`endif

  // Decode of the incoming request: single-cycle results and routing.
  always_comb begin
    w_f_fast   = 1'b0;
    w_f_div    = 1'b0;
    w_f_result = '0;
    w_f_rem    = '0;
    w_f_flag   = '0;
    w_f_dbz    = 1'b0;
    w_f_ill    = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_f_fast          = 1'b1;
        w_f_result        = w_a_ext + w_b_ext;
        w_f_flag[OPF_ADD] = 1'b1;
      end
      OP_SUB: begin
        w_f_fast          = 1'b1;
        w_f_result        = w_a_ext - w_b_ext;
        w_f_flag[OPF_SUB] = 1'b1;
      end
      OP_MUL: begin
        w_f_fast = 1'b0;
      end
      OP_DIV: begin
        w_f_div = 1'b1;
        if (bus.b == '0) begin
          w_f_fast          = 1'b1;
          w_f_result        = '1;
          w_f_rem           = bus.a;
          w_f_dbz           = 1'b1;
          w_f_flag[OPF_DIV] = 1'b1;
        end
      end
      default: begin
        w_f_fast = 1'b1;
        w_f_ill  = 1'b1;
      end
    endcase
  end

  seq_calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .i_load     (w_accept),
    .i_step     (r_state == RUN),
    .i_mode     (w_accept ? (w_f_div ? MODE_DIV : MODE_MUL)
                          : (r_is_div ? MODE_DIV : MODE_MUL)),
    .i_a        (magnitude(bus.a)),
    .i_b        (magnitude(bus.b)),
    .o_prod_nxt (w_prod_nxt),
    .o_quo_nxt  (w_quo_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  // Control FSM: next state and iteration counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_f_fast) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = RUN;
            w_cnt_nxt   = CNT_W'(WIDTH - 1);
          end
        end
      end
      RUN: begin
        if (r_cnt == '0) w_state_nxt = FIN;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operation context kept for the iterative path.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= w_f_div;
      r_neg_q  <= w_neg_q;
      r_neg_r  <= w_neg_r;
    end
  end

  // Output registers: loaded only on the edge that enters FIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result      <= '0;
      r_remainder   <= '0;
      r_op_flag     <= '0;
      r_div_by_zero <= 1'b0;
      r_illegal_op  <= 1'b0;
    end else if (w_fin_fast) begin
      r_result      <= w_f_result;
      r_remainder   <= w_f_rem;
      r_op_flag     <= w_f_flag;
      r_div_by_zero <= w_f_dbz;
      r_illegal_op  <= w_f_ill;
    end else if (w_fin_iter) begin
      r_div_by_zero <= 1'b0;
      r_illegal_op  <= 1'b0;
      r_op_flag     <= '0;
      if (r_is_div) begin
        r_result             <= apply_sign_res({{WIDTH{1'b0}}, w_quo_nxt}, r_neg_q);
        r_remainder          <= apply_sign_rem(w_rem_nxt, r_neg_r);
        r_op_flag[OPF_DIV]   <= 1'b1;
      end else begin
        r_result             <= apply_sign_res(w_prod_nxt, r_neg_q);
        r_remainder          <= '0;
        r_op_flag[OPF_MUL]   <= 1'b1;
      end
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == FIN);
  assign bus.result      = r_result;
  assign bus.remainder   = r_remainder;
  assign bus.op_flag     = r_op_flag;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [RW-1:0] last_res = '0;

  always #5 clk = ~clk;

  seq_calc_if #(.WIDTH(W)) bus ();

  seq_calculator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the operand values.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [RW-1:0] res, output logic [W-1:0] rem,
                                output logic [3:0] flg, output logic dbz, output logic ill,
                                output int lat);
    longint sa, sb, q, r;
`ifdef SEQ_CALC_SIGNED_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`else
    sa = longint'(a);
    sb = longint'(b);
`endif
    res = '0; rem = '0; flg = '0; dbz = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      3'd0: begin res = RW'(sa + sb); flg = 4'b0001; end
      3'd1: begin res = RW'(sa - sb); flg = 4'b0010; end
      3'd2: begin res = RW'(sa * sb); flg = 4'b0100; lat = W + 1; end
      3'd3: begin
        flg = 4'b1000;
        if (sb == 0) begin
          res = '1; rem = a; dbz = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          res = RW'(q); rem = W'(r); lat = W + 1;
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op at a negedge, then track it to completion.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, output logic [RW-1:0] res_got);
    logic [RW-1:0] e_res;
    logic [W-1:0]  e_rem;
    logic [3:0]    e_flg;
    logic          e_dbz, e_ill;
    int            e_lat, lat;
    model(op, a, b, e_res, e_rem, e_flg, e_dbz, e_ill, e_lat);
    @(negedge clk);
    check_val("hold_before_accept", bus.result, last_res);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      check_val("busy_in_run", bus.busy, 1'b1);
      if (lat == 1) check_val("hold_in_run", bus.result, last_res);
      if (poke && lat == 3) begin
        bus.start = 1'b1; bus.op = 3'($urandom_range(0, 7));
        bus.a = W'($urandom); bus.b = W'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    check_val("latency", lat, e_lat);
    check_val("busy_at_done", bus.busy, 1'b1);
    check_val("result", bus.result, e_res);
    check_val("remainder", bus.remainder, e_rem);
    check_val("op_flag", bus.op_flag, e_flg);
    check_val("div_by_zero", bus.div_by_zero, e_dbz);
    check_val("illegal_op", bus.illegal_op, e_ill);
    res_got = bus.result;
    last_res = e_res;
    @(negedge clk);
    check_val("done_pulse", bus.done, 1'b0);
    check_val("busy_after", bus.busy, 1'b0);
    check_val("result_held", bus.result, e_res);
  endtask

  initial begin
    logic [RW-1:0] r;
    int dones;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_done", bus.done, 1'b0);
    check_val("rst_result", bus.result, '0);
    check_val("rst_remainder", bus.remainder, '0);
    check_val("rst_flags", {bus.op_flag, bus.div_by_zero, bus.illegal_op}, '0);
    rst_n = 1'b1;

`ifdef SEQ_CALC_SIGNED_EN
    run_op(3'd2, 8'hF9, 8'd3, 1'b0, r);  check_val("s_mul_m7x3", r, 16'hFFEB);
    run_op(3'd3, 8'hF9, 8'd2, 1'b0, r);  check_val("s_div_m7d2", r, 16'hFFFD);
    check_val("s_rem_m7d2", bus.remainder, 8'hFF);
    run_op(3'd3, 8'h80, 8'hFF, 1'b0, r); check_val("s_div_min", r, 16'h0080);
    run_op(3'd1, 8'd3, 8'd5, 1'b0, r);   check_val("s_sub_3m5", r, 16'hFFFE);
`else
    run_op(3'd0, 8'd200, 8'd100, 1'b0, r); check_val("add_200_100", r, 16'h012C);
    run_op(3'd1, 8'd3, 8'd5, 1'b0, r);     check_val("sub_3_5", r, 16'hFFFE);
    run_op(3'd2, 8'd255, 8'd255, 1'b1, r); check_val("mul_255", r, 16'hFE01);
    run_op(3'd3, 8'd200, 8'd7, 1'b0, r);   check_val("div_200_7", r, 16'h001C);
    check_val("rem_200_7", bus.remainder, 8'h04);
    run_op(3'd3, 8'd17, 8'd0, 1'b0, r);    check_val("div_17_0", r, 16'hFFFF);
    check_val("rem_17_0", bus.remainder, 8'h11);
`endif
    run_op(3'd5, 8'd9, 8'd4, 1'b0, r);     check_val("illegal_res", r, '0);

    // Reset in the middle of a multiply.
    run_op(3'd2, 8'd13, 8'd11, 1'b0, r);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 8'd99; bus.b = 8'd77;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_busy", bus.busy, 1'b0);
    check_val("abort_done", bus.done, 1'b0);
    check_val("abort_result", bus.result, '0);
    check_val("abort_flags", {bus.op_flag, bus.div_by_zero, bus.illegal_op}, '0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_val("abort_no_done", dones, 0);
    last_res = '0;

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(op, a, b, bit'($urandom_range(0, 1)), r);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
Name:
seq_calculator

Overview:
- Multi-cycle, parametrised-width arithmetic unit: add, subtract, multiply, divide with remainder.
- Operands and opcode are captured on a start/busy/done handshake.
- Add/sub complete in one cycle; mul/div iterate one bit per cycle through a shared shift unit.
- Sits behind a control FSM or bus front-end that issues one operation at a time.

Parameters:
- WIDTH, 8, operand width in bits (≥2). Result width RES_W = 2*WIDTH is a localparam.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  3  0=ADD 1=SUB 2=MUL 3=DIV, 4..7 illegal.
- a  in  WIDTH  first operand / dividend.
- b  in  WIDTH  second operand / divisor.
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse: result valid.
- result  out  RES_W  sum/difference/product/quotient.
- remainder  out  WIDTH  DIV remainder; 0 for other ops.
- op_flag  out  4  one-hot completed op: [0]add [1]sub [2]mul [3]div.
- div_by_zero  out  1  set with done when DIV and b==0.
- illegal_op  out  1  set with done when op ≥ 4.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; all outputs 0. Takes priority mid-operation: the in-flight op is aborted and no done is produced.
- FSM states:
  - IDLE: start=1 accepts at edge k; a, b, op are latched.
    - ADD/SUB, DIV with b==0, or illegal op → FIN.
    - MUL/DIV with b≠0 → RUN, cycle counter = WIDTH-1.
  - RUN: one iteration per cycle; counter decrements; on counter==0 → FIN.
  - FIN: done=1 and busy=1 for exactly one cycle → IDLE.
- Latency:
  - ADD/SUB/error cases: done in the cycle after accept (1).
  - MUL/DIV: done WIDTH+1 cycles after accept.
  - Earliest next accept is the edge ending FIN's successor IDLE cycle, i.e. no back-to-back in FIN.
- start while busy=1 (RUN or FIN) is ignored; no queuing. Inputs are don't-care after accept.
- Outputs result, remainder, op_flag, div_by_zero and illegal_op update only on entering FIN. They hold until the next FIN; they are not cleared on accept.
- Arithmetic, unsigned build:
  - ADD: zero-extended sum.
  - SUB: a−b two's complement, sign-extended to RES_W.
  - MUL: shift-add, full RES_W product.
  - DIV: restoring; quotient zero-extended.
- DIV by zero: result = all ones, remainder = a, div_by_zero=1, op_flag[3]=1.
- Illegal op: result=0, remainder=0, op_flag=0, illegal_op=1.

Optional Feature:
- SEQ_CALC_SIGNED_EN defined: a and b are two's complement for all ops.
  - ADD/SUB sign-extend both operands.
  - MUL/DIV run on magnitudes, then sign-correct.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative ÷ −1 gives +2^(WIDTH-1) in RES_W (no overflow flag).
  - Latency is unchanged.
- Undefined: unsigned behaviour as above.

Decomposition:
- Package seq_calc_pkg holds:
  - op encodings OP_ADD..OP_DIV;
  - state enum {IDLE, RUN, FIN};
  - op_flag bit indices.
- One sub-module, seq_calc_iter_unit: shared WIDTH-cycle shift datapath (shift-add multiply / restoring divide), selected by a mode bit.
- Top level keeps the FSM, operand latch, sign handling and output registers.

Test Plan (WIDTH=8):
- ADD 200+100 → result 0x012C, op_flag 0001, done 1 cycle after accept; SUB 3−5 → 0xFFFE, op_flag 0010.
- MUL 255×255 → 0xFE01, done exactly 9 cycles after accept; start pulsed mid-RUN is ignored, and only one done occurs.
- DIV 200/7 → result 0x001C, remainder 0x04, latency 9; DIV 17/0 → result 0xFFFF, remainder 0x11, div_by_zero=1, latency 1.
- op=5 → result 0, illegal_op=1, op_flag 0000; prior result is held until then. Reset asserted at cycle 4 of a MUL → outputs 0, no done, IDLE next cycle.
- SEQ_CALC_SIGNED_EN: −7×3 → 0xFFEB; −7/2 → result 0xFFFD, remainder 0xFF; −128/−1 → 0x0080.
